// File: rtl/wavetable_voice_mixer.sv
// Polyphonic wavetable playback engine. Each accepted sample_tick starts a frame.
// A frame reads one table word per voice through a single read port with
// one cycle of latency. It sums the signed samples and saturates the total
// into sample_out.
module wavetable_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int PHASE_W    = 24
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [NUM_VOICES*PHASE_W-1:0] voice_inc,
  input  logic                          overrun_clr,
  output logic [ADDR_W-1:0]             mem_address,
  output logic                          mem_chipselect,
  output logic                          mem_clken,
  output logic                          mem_write,
  output logic [DATA_W/8-1:0]           mem_byteenable,
  input  logic [DATA_W-1:0]             mem_readdata,
  output logic [DATA_W-1:0]             sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W  = DATA_W + $clog2(NUM_VOICES) + 1;
  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [VIDX_W-1:0]               v_q, v_d;
  logic [NUM_VOICES-1:0]           en_q, en_d;
  logic [NUM_VOICES*PHASE_W-1:0]   inc_q, inc_d;
  logic [PHASE_W-1:0]              phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]              phase_d [NUM_VOICES];
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic                            rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]               sample_q, sample_d;
  logic                            valid_q, valid_d;
  logic                            overrun_q, overrun_d;

  logic                            cur_en;
  logic [PHASE_W-1:0]              cur_phase, cur_inc;
  logic signed [ACC_W-1:0]         rd_ext, sum;
  logic [DATA_W-1:0]               sat_val;

  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign sample_out     = sample_q;
  assign sample_valid   = valid_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != S_IDLE);

  // Next-state logic: frame sequencing, read issue, accumulate and saturate.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d        = state_q;
    v_d            = v_q;
    en_d           = en_q;
    inc_d          = inc_q;
    phase_d        = phase_q;
    acc_d          = acc_q;
    rd_pend_d      = 1'b0;
    sample_d       = sample_q;
    valid_d        = 1'b0;
    overrun_d      = overrun_q;
    mem_address    = '0;
    mem_chipselect = 1'b0;

    cur_en    = en_q[v_q];
    cur_phase = phase_q[v_q];
    cur_inc   = inc_q[int'(v_q)*PHASE_W +: PHASE_W];

    // Data from the previous cycle's read is folded in one cycle after issue.
    rd_ext = {{(ACC_W-DATA_W){mem_readdata[DATA_W-1]}}, mem_readdata};
    if (rd_pend_q) sum = acc_q + rd_ext;
    else           sum = acc_q;

    if (sum > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                    sat_val = sum[DATA_W-1:0];

    // Clear first so a coincident overrun event takes priority.
    if (overrun_clr) overrun_d = 1'b0;
    if (sample_tick && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          en_d    = voice_en;
          inc_d   = voice_inc;
          acc_d   = '0;
          v_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        acc_d = sum;
        if (cur_en) begin
          // Address comes from the pre-increment phase.
          mem_address    = cur_phase[PHASE_W-1 -: ADDR_W];
          mem_chipselect = 1'b1;
          rd_pend_d      = 1'b1;
          phase_d[v_q]   = cur_phase + cur_inc;
        end else begin
          // A disabled voice restarts from address 0 when re-enabled.
          phase_d[v_q] = '0;
        end
        if (v_q == LAST_V) state_d = S_DRAIN;
        else               v_d     = v_q + 1'b1;
      end
      S_DRAIN: begin
        acc_d    = sum;
        sample_d = sat_val;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its next value from the same pre-edge snapshot.
      state_q   <= S_IDLE;
      v_q       <= '0;
      en_q      <= '0;
      inc_q     <= '0;
      acc_q     <= '0;
      rd_pend_q <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the phase array is a small set of flops, not a RAM, so it is
      // safe and required to clear it in reset.
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      en_q      <= en_d;
      inc_q     <= inc_d;
      acc_q     <= acc_d;
      rd_pend_q <= rd_pend_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      phase_q   <= phase_d;
    end
  end

endmodule

// File: tb/tb_wavetable_voice_mixer.sv
// Self-checking bench for wavetable_voice_mixer (4 voices, 13-bit address,
// 16-bit data, 24-bit phase). A table of frames covers the mixing behaviour;
// hand-written sequences cover reset, overrun, back-to-back ticks and wrap.
module tb_wavetable_voice_mixer;

  localparam logic [23:0] STEP   = 24'h000800;
  localparam logic [95:0] INC_A  = {72'h0, STEP};
  localparam logic [95:0] INC_DN = {72'h0, 24'hFFF800};
  localparam logic [95:0] INC_M  = {STEP, 24'h0, 24'h001800, STEP};

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [3:0]  voice_en = '0;
  logic [95:0] voice_inc = '0;
  logic        overrun_clr = 1'b0;
  logic [12:0] mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata = '0;
  logic [15:0] sample_out;
  logic        sample_valid, busy, overrun;

  logic        rmode = 1'b0;   // 0: readdata echoes address, 1: constant
  logic [15:0] rconst = '0;

  int total = 0;
  int bad   = 0;

  wavetable_voice_mixer #(
    .NUM_VOICES(4), .ADDR_W(13), .DATA_W(16), .PHASE_W(24)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .sample_tick(sample_tick),
    .voice_en(voice_en), .voice_inc(voice_inc), .overrun_clr(overrun_clr),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk_clk = ~clk_clk;

  // Memory model: one cycle read latency; junk when no read was issued.
  always @(posedge clk_clk) begin
    if (mem_chipselect) mem_readdata <= rmode ? rconst : {3'b000, mem_address};
    else                mem_readdata <= 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  // One frame: tick in cycle T, observe cycles T+1..T+12 at the falling edge.
  task automatic frame(input int second_k, input int clr_k,
                       output int reads, output logic [12:0] addr0,
                       output int valid_k, output int valid_n,
                       output logic [15:0] samp, output int busy_err,
                       output logic ovr3);
    logic [3:0]  en_save;
    logic [95:0] inc_save;
    logic        exp_busy;
    reads = 0; addr0 = '0; valid_k = 0; valid_n = 0; samp = '0; busy_err = 0; ovr3 = 1'b0;
    en_save = voice_en;
    inc_save = voice_inc;
    @(negedge clk_clk);
    sample_tick = 1'b1;
    @(negedge clk_clk);
    sample_tick = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (mem_chipselect) begin
        if (reads == 0) addr0 = mem_address;
        reads++;
      end
      if (sample_valid) begin
        valid_n++;
        if (valid_k == 0) begin
          valid_k = k;
          samp = sample_out;
        end
      end
      exp_busy = (k <= 5) || (second_k == 6 && k >= 7 && k <= 11);
      if (busy !== exp_busy) busy_err++;
      if (k == 3) ovr3 = overrun;
      // Mid-frame input changes must not disturb the running frame.
      if (k == 1) begin
        voice_en = ~en_save;
        voice_inc = ~inc_save;
      end
      sample_tick = (k == second_k);
      overrun_clr = (k == clr_k);
      @(negedge clk_clk);
    end
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    voice_en = en_save;
    voice_inc = inc_save;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [95:0] inc;
    logic        rm;
    logic [15:0] rc;
    int          reads;
    logic [12:0] addr0;
    logic [15:0] samp;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int          reads, valid_k, valid_n, busy_err, werr, vcnt, ccnt;
    logic [12:0] addr0, a_last, a_wrap;
    logic [15:0] samp;
    logic        ovr3;

    // Playback, disable/re-enable, saturation, reverse wrap and mixing.
    vecs[0]  = '{1'b1, 4'b0001, INC_A,  1'b0, 16'h0000, 1, 13'd0,    16'h0000};
    vecs[1]  = '{1'b0, 4'b0001, INC_A,  1'b0, 16'h0000, 1, 13'd1,    16'h0001};
    vecs[2]  = '{1'b0, 4'b0001, INC_A,  1'b0, 16'h0000, 1, 13'd2,    16'h0002};
    vecs[3]  = '{1'b0, 4'b0001, INC_A,  1'b0, 16'h0000, 1, 13'd3,    16'h0003};
    vecs[4]  = '{1'b0, 4'b0001, INC_A,  1'b0, 16'h0000, 1, 13'd4,    16'h0004};
    vecs[5]  = '{1'b0, 4'b0000, INC_A,  1'b0, 16'h0000, 0, 13'd0,    16'h0000};
    vecs[6]  = '{1'b0, 4'b0001, INC_A,  1'b0, 16'h0000, 1, 13'd0,    16'h0000};
    vecs[7]  = '{1'b1, 4'b1111, 96'h0,  1'b1, 16'h7000, 4, 13'd0,    16'h7FFF};
    vecs[8]  = '{1'b0, 4'b1111, 96'h0,  1'b1, 16'h9000, 4, 13'd0,    16'h8000};
    vecs[9]  = '{1'b0, 4'b1111, 96'h0,  1'b1, 16'h0100, 4, 13'd0,    16'h0400};
    vecs[10] = '{1'b1, 4'b0001, INC_DN, 1'b0, 16'h0000, 1, 13'd0,    16'h0000};
    vecs[11] = '{1'b0, 4'b0001, INC_DN, 1'b0, 16'h0000, 1, 13'd8191, 16'h1FFF};
    vecs[12] = '{1'b0, 4'b0001, INC_DN, 1'b0, 16'h0000, 1, 13'd8190, 16'h1FFE};
    vecs[13] = '{1'b1, 4'b0011, INC_M,  1'b0, 16'h0000, 2, 13'd0,    16'h0000};
    vecs[14] = '{1'b0, 4'b0011, INC_M,  1'b0, 16'h0000, 2, 13'd1,    16'h0004};
    vecs[15] = '{1'b0, 4'b1010, INC_M,  1'b0, 16'h0000, 2, 13'd6,    16'h0006};
    vecs[16] = '{1'b0, 4'b1111, INC_M,  1'b0, 16'h0000, 4, 13'd0,    16'h000A};

    // Reset state.
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_sample", sample_out, 16'h0000);
    check("rst_cs", mem_chipselect, 1'b0);
    check("rst_addr", mem_address, 13'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_clken", mem_clken, 1'b1);
    check("rst_write", mem_write, 1'b0);
    check("rst_be", mem_byteenable, 2'b11);

    // Table-driven frames.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) do_reset();
      voice_en = vecs[i].en;
      voice_inc = vecs[i].inc;
      rmode = vecs[i].rm;
      rconst = vecs[i].rc;
      frame(0, 0, reads, addr0, valid_k, valid_n, samp, busy_err, ovr3);
      check($sformatf("v%0d_reads", i), reads, vecs[i].reads);
      check($sformatf("v%0d_addr0", i), addr0, vecs[i].addr0);
      check($sformatf("v%0d_sample", i), samp, vecs[i].samp);
      check($sformatf("v%0d_valid_cycle", i), valid_k, 6);
      check($sformatf("v%0d_valid_count", i), valid_n, 1);
      check($sformatf("v%0d_busy", i), busy_err, 0);
    end

    // Reset mid-frame: sample_out was 16'h7FFF before the aborted frame.
    do_reset();
    voice_en = 4'b1111; voice_inc = '0; rmode = 1'b1; rconst = 16'h7000;
    frame(0, 0, reads, addr0, valid_k, valid_n, samp, busy_err, ovr3);
    check("mr_pre_sample", sample_out, 16'h7FFF);
    @(negedge clk_clk); sample_tick = 1'b1;
    @(negedge clk_clk); sample_tick = 1'b0;   // T+1
    @(negedge clk_clk);                       // T+2
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    check("mr_busy", busy, 1'b0);
    check("mr_sample", sample_out, 16'h0000);
    check("mr_cs", mem_chipselect, 1'b0);
    vcnt = 0; ccnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (sample_valid) vcnt++;
      if (mem_chipselect) ccnt++;
      @(negedge clk_clk);
    end
    check("mr_no_valid", vcnt, 0);
    check("mr_no_cs", ccnt, 0);
    check("mr_sample_hold", sample_out, 16'h0000);

    // Overrun: second tick at T+2 is ignored and sets the sticky flag.
    do_reset();
    voice_en = 4'b1111; voice_inc = '0; rmode = 1'b1; rconst = 16'h0100;
    frame(2, 0, reads, addr0, valid_k, valid_n, samp, busy_err, ovr3);
    check("ov_valid_count", valid_n, 1);
    check("ov_valid_cycle", valid_k, 6);
    check("ov_sample", samp, 16'h0400);
    check("ov_busy", busy_err, 0);
    check("ov_set_t3", ovr3, 1'b1);
    check("ov_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk_clk);
    overrun_clr = 1'b0;
    check("ov_cleared", overrun, 1'b0);
    // Clear coinciding with a new overrun event: set wins.
    frame(2, 2, reads, addr0, valid_k, valid_n, samp, busy_err, ovr3);
    check("ov_set_wins", ovr3, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk_clk);
    overrun_clr = 1'b0;
    // Tick in T+6 is accepted: second frame, no overrun.
    frame(6, 0, reads, addr0, valid_k, valid_n, samp, busy_err, ovr3);
    check("b2b_valid_count", valid_n, 2);
    check("b2b_busy", busy_err, 0);
    check("b2b_no_overrun", overrun, 1'b0);

    // Forward wrap: 8193 back-to-back frames, addresses 0..8191 then 0.
    do_reset();
    voice_en = 4'b0001; voice_inc = INC_A; rmode = 1'b0;
    werr = 0; a_last = '0; a_wrap = '1;
    @(negedge clk_clk);
    for (int i = 0; i <= 8192; i++) begin
      sample_tick = 1'b1;
      @(negedge clk_clk);
      sample_tick = 1'b0;   // T+1: voice 0 read
      if (!mem_chipselect || mem_address !== 13'(i % 8192)) werr++;
      if (i == 8191) a_last = mem_address;
      if (i == 8192) a_wrap = mem_address;
      repeat (5) @(negedge clk_clk);
    end
    check("wrap_seq_errors", werr, 0);
    check("wrap_last", a_last, 13'd8191);
    check("wrap_zero", a_wrap, 13'd0);
    check("wrap_no_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
